// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the data-memory arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DUMP, HALTED} arb_state_t;
   typedef enum logic [1:0] {NONE, IF, DM} arb_owner_t;

   localparam int CNT_W    = 4;
   localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational grant decision: dump, data port, or fetch
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 3
) (
   input  logic                if_req,
   input  logic                dm_req,
   input  logic [STARVE_W-1:0] starve_cnt,
   input  logic                halt,
   output arb_owner_t          grant,
   output logic                dump
);

   logic starved;

   // Starvation only matters while fetch is actually waiting; otherwise the
   // data port could lock itself out after fetch drops its request.
   assign starved = (STARVE_LIMIT != 0) && if_req &&
                    (starve_cnt == STARVE_W'(STARVE_LIMIT));

   always_comb begin
      grant = NONE;
      dump  = 1'b0;
      if (halt) begin
         dump = 1'b1;
      end else if (dm_req && !starved) begin
         grant = DM;
      end else if (if_req) begin
         grant = IF;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the single-ported data memory between fetch and memory stage
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LATENCY      = 1,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_done,
   output logic [15:0] if_rdata,
   input  logic        dm_rd,
   input  logic        dm_wr,
   input  logic [15:0] dm_addr,
   input  logic [15:0] dm_wdata,
   output logic        dm_done,
   output logic [15:0] dm_rdata,
   output logic        dm_err,
   input  logic        halt,
   output logic        halted,
   output logic        mem_en,
   output logic        mem_wr,
   output logic        mem_dump,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
);

   arb_state_t          state_q, state_d;
   arb_owner_t          owner_q, owner_d;
   arb_owner_t          pick_owner;
   logic                pick_dump;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic [15:0]         addr_q, addr_d;
   logic [15:0]         wdata_q, wdata_d;
   logic                wr_q, wr_d;
   logic                err_q, err_d;
   logic [15:0]         if_hold_q, dm_hold_q;
   logic                if_fire, dm_fire;
   logic                dm_req;

   assign dm_req = dm_rd | dm_wr;

   mem_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_pick (
      .if_req     (if_req),
      .dm_req     (dm_req),
      .starve_cnt (starve_q),
      .halt       (halt),
      .grant      (pick_owner),
      .dump       (pick_dump)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         owner_q   <= NONE;
         cnt_q     <= '0;
         starve_q  <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         err_q     <= 1'b0;
         if_hold_q <= '0;
         dm_hold_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
         err_q    <= err_d;
         if (if_done) if_hold_q <= if_rdata;
         if (dm_done) dm_hold_q <= dm_rdata;
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      starve_d = starve_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wr_d     = wr_q;
      err_d    = 1'b0;
      mem_en   = 1'b0;
      mem_wr   = 1'b0;
      mem_dump = 1'b0;
      halted   = 1'b0;
      if_fire  = 1'b0;
      dm_fire  = 1'b0;

      case (state_q)
         IDLE: begin
            // The cycle carrying an error response makes no new decision, so a
            // requester still holding rd&wr cannot trigger a second pulse.
            if (!err_q) begin
               if (pick_dump) begin
                  state_d = DUMP;
               end else if (pick_owner == DM && dm_rd && dm_wr) begin
                  err_d = 1'b1;
               end else if (pick_owner != NONE) begin
                  owner_d = pick_owner;
                  cnt_d   = CNT_W'(1);
                  state_d = BUSY;
                  if (pick_owner == DM) begin
                     addr_d  = dm_addr;
                     wdata_d = dm_wdata;
                     wr_d    = dm_wr;
                     if (if_req && (starve_q < STARVE_W'(STARVE_LIMIT)))
                        starve_d = starve_q + STARVE_W'(1);
                  end else begin
                     addr_d   = if_addr;
                     wdata_d  = '0;
                     wr_d     = 1'b0;
                     starve_d = '0;
                  end
               end
            end
         end
         BUSY: begin
            mem_en = (cnt_q == CNT_W'(1));
            mem_wr = mem_en & wr_q;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(LATENCY)) begin
               if_fire = (owner_q == IF);
               dm_fire = (owner_q == DM);
               owner_d = NONE;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         DUMP: begin
            mem_dump = 1'b1;
            state_d  = HALTED;
         end
         HALTED: begin
            halted = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   assign if_done  = if_fire;
   assign if_rdata = if_fire ? mem_rdata : if_hold_q;

   assign dm_done  = dm_fire | err_q;
   assign dm_err   = err_q;
   assign dm_rdata = dm_fire ? (wr_q ? 16'h0000 : mem_rdata) :
                     err_q   ? 16'h0000 : dm_hold_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter at LATENCY 1 and 3
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = '0;
   logic        dm_rd = 1'b0;
   logic        dm_wr = 1'b0;
   logic [15:0] dm_addr = '0;
   logic [15:0] dm_wdata = '0;
   logic        halt = 1'b0;
   logic [15:0] mem_rdata = 16'h1234;

   logic        if_done_1, dm_done_1, dm_err_1, halted_1, mem_en_1, mem_wr_1, mem_dump_1;
   logic [15:0] if_rdata_1, dm_rdata_1, mem_addr_1, mem_wdata_1;
   logic        if_done_3, dm_done_3, dm_err_3, halted_3, mem_en_3, mem_wr_3, mem_dump_3;
   logic [15:0] if_rdata_3, dm_rdata_3, mem_addr_3, mem_wdata_3;

   int n_checks = 0;
   int n_pass   = 0;

   mem_arbiter #(.LATENCY(1), .STARVE_LIMIT(3)) u_l1 (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done_1), .if_rdata(if_rdata_1),
      .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_done(dm_done_1), .dm_rdata(dm_rdata_1), .dm_err(dm_err_1),
      .halt(halt), .halted(halted_1),
      .mem_en(mem_en_1), .mem_wr(mem_wr_1), .mem_dump(mem_dump_1),
      .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.LATENCY(3), .STARVE_LIMIT(3)) u_l3 (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done_3), .if_rdata(if_rdata_3),
      .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_done(dm_done_3), .dm_rdata(dm_rdata_3), .dm_err(dm_err_3),
      .halt(halt), .halted(halted_3),
      .mem_en(mem_en_3), .mem_wr(mem_wr_3), .mem_dump(mem_dump_3),
      .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0; halt = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   function automatic logic [127:0] outs_l3();
      return {if_done_3, if_rdata_3, dm_done_3, dm_rdata_3, dm_err_3, halted_3,
              mem_en_3, mem_wr_3, mem_dump_3, mem_addr_3, mem_wdata_3};
   endfunction

   initial begin
      int ev[$];
      int exp_seq[8] = '{2, 2, 2, 1, 2, 2, 2, 1};
      logic both, seen, bad;
      int lat;

      // Reset state
      @(negedge clk);
      check("reset_outs_l1", {if_done_1, if_rdata_1, dm_done_1, dm_rdata_1, dm_err_1, halted_1,
                              mem_en_1, mem_wr_1, mem_dump_1, mem_addr_1, mem_wdata_1}, '0);
      check("reset_outs_l3", outs_l3(), '0);
      do_reset();

      // Fetch read, LATENCY=1
      if_req = 1'b1; if_addr = 16'h0040;
      @(negedge clk);
      check("if_mem_en", {mem_en_1, mem_wr_1, mem_addr_1}, {1'b1, 1'b0, 16'h0040});
      check("if_done", {if_done_1, dm_done_1, if_rdata_1}, {1'b1, 1'b0, 16'h1234});
      if_req = 1'b0;
      @(negedge clk);
      check("if_after", {if_done_1, dm_done_1, mem_en_1, if_rdata_1}, {1'b0, 1'b0, 1'b0, 16'h1234});

      // Starvation guard: both ports held, expect DM DM DM IF repeating
      do_reset();
      if_req = 1'b1; if_addr = 16'h0010; dm_rd = 1'b1; dm_addr = 16'h0020;
      both = 1'b0;
      for (int i = 0; i < 60 && ev.size() < 8; i++) begin
         @(negedge clk);
         if (if_done_1 && dm_done_1) both = 1'b1;
         if (dm_done_1) ev.push_back(2);
         else if (if_done_1) ev.push_back(1);
      end
      if_req = 1'b0; dm_rd = 1'b0;
      check("starve_count", ev.size(), 8);
      check("starve_both_done", both, 1'b0);
      for (int i = 0; i < 8; i++) check($sformatf("starve_seq%0d", i), ev[i], exp_seq[i]);

      // Read+write together: error pulse, no issue
      @(negedge clk);
      dm_rd = 1'b1; dm_wr = 1'b1;
      @(negedge clk);
      check("err_pulse", {dm_done_1, dm_err_1, dm_rdata_1, mem_en_1, if_done_1},
            {1'b1, 1'b1, 16'h0000, 1'b0, 1'b0});
      dm_rd = 1'b0; dm_wr = 1'b0;
      @(negedge clk);
      check("err_after", {dm_done_1, dm_err_1, mem_en_1}, 3'b000);

      // Data read, LATENCY=3
      do_reset();
      dm_rd = 1'b1; dm_addr = 16'h0200; mem_rdata = 16'hA5A5;
      seen = 1'b0; bad = 1'b0; lat = 0;
      for (int i = 1; i <= 10 && !seen; i++) begin
         @(negedge clk);
         if (mem_wr_3) bad = 1'b1;
         if (dm_done_3) begin seen = 1'b1; lat = i; end
      end
      check("rd3_done_seen", seen, 1'b1);
      check("rd3_latency", lat, 3);
      check("rd3_rdata", {dm_rdata_3, bad}, {16'hA5A5, 1'b0});
      dm_rd = 1'b0;
      @(negedge clk);

      // Data write, LATENCY=3
      dm_wr = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'hBEEF;
      @(negedge clk);
      check("wr3_issue", {mem_en_3, mem_wr_3, mem_addr_3, mem_wdata_3, dm_done_3},
            {1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0});
      @(negedge clk);
      check("wr3_wait", {mem_en_3, mem_wr_3, dm_done_3}, 3'b000);
      @(negedge clk);
      check("wr3_done", {dm_done_3, dm_err_3, dm_rdata_3, if_done_3, mem_en_3},
            {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
      dm_wr = 1'b0;
      @(negedge clk);
      check("wr3_after", {dm_done_3, dm_rdata_3}, {1'b0, 16'h0000});

      // Halt during BUSY: access completes, then dump, then halted
      do_reset();
      if_req = 1'b1; if_addr = 16'h0080; mem_rdata = 16'h4321;
      @(negedge clk);
      halt = 1'b1;
      @(negedge clk);
      check("halt_busy", {if_done_3, mem_dump_3}, 2'b00);
      @(negedge clk);
      check("halt_done", {if_done_3, if_rdata_3, mem_dump_3}, {1'b1, 16'h4321, 1'b0});
      if_req = 1'b0;
      @(negedge clk);
      check("halt_idle", {mem_dump_3, halted_3}, 2'b00);
      @(negedge clk);
      check("halt_dump", {mem_dump_3, mem_en_3, halted_3}, 3'b100);
      @(negedge clk);
      check("halt_halted", {mem_dump_3, halted_3}, 2'b01);
      halt = 1'b0; if_req = 1'b1; dm_rd = 1'b1;
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (mem_en_3 || if_done_3 || dm_done_3 || !halted_3) bad = 1'b1;
      end
      check("halted_ignores", bad, 1'b0);

      // Reset in the middle of a LATENCY=3 read
      do_reset();
      @(negedge clk);
      check("post_reset_halted", halted_3, 1'b0);
      if_req = 1'b1; if_addr = 16'h0090;
      @(negedge clk);
      check("mid_issue", {mem_en_3, mem_addr_3}, {1'b1, 16'h0090});
      #2;
      rst = 1'b0; if_req = 1'b0; dm_rd = 1'b0;
      #1;
      check("mid_reset_outs", outs_l3(), '0);
      @(negedge clk);
      rst = 1'b1;
      bad = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (if_done_3 || dm_done_3 || mem_en_3) bad = 1'b1;
      end
      check("mid_no_done", bad, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
